grp_pingpong_ctrl: RTL and testbench
====================================

Name: grp_pingpong_ctrl

Overview:
- Controller for the two group buffers (bank 0 / bank 1) between the Orbita-M8 frame filler (writer) and the M8 frame former (reader).
- Owns the bank-select state and gates the write/read enables of both buffers.
- Swaps banks only when the written group is complete and the reader reaches a group boundary.
- Muxes buffer read data with correct latency alignment, and reports underrun/overrun with saturating counters.

Parameters:
- DATA_W, 12, width of a group-buffer word
- ADDR_W, 10, group-buffer address width
- CNT_W, 8, width of the underrun/overrun counters

Ports:
- clk  in  1  system clock (clk80 domain); reader-side strobes are already synchronised to it
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  filler write strobe
- wr_addr  in  ADDR_W  filler write address
- wr_done  in  1  one-cycle pulse: filler finished the current group
- fill_req  out  1  one-cycle pulse: filler may start a new group
- rd_en  in  1  reader read strobe
- rd_swap  in  1  one-cycle pulse: reader at group end, requests the next group
- m0_we, m1_we  out  1  bank write enables
- m0_re, m1_re  out  1  bank read enables
- m0_do, m1_do  in  DATA_W  bank read data, 1-cycle read latency
- rd_data  out  DATA_W  read data delivered to the reader
- bank_sel  out  1  bank currently owned by the reader; the writer owns ~bank_sel
- underrun_cnt  out  CNT_W  saturating count of swap requests refused because no group was ready
- overrun_cnt  out  CNT_W  saturating count of write strobes and wr_done pulses rejected while the write bank is full

Behaviour:
- Reset values:
  - bank_sel=0, state=FILL, fill_req=0
  - all we/re = 0, rd_data=0
  - both counters = 0, internal sel_d=0
- The cycle after reset is released, fill_req pulses once.
- States:
  - FILL: writer bank is open.
  - READY: writer bank holds a complete group and is locked.
- Enables are combinational from the current state:
  - m{~bank_sel}_we = wr_en & (state==FILL)
  - m{bank_sel}_re = rd_en
  - The other bank's re and we are 0.
- Write address passes straight through to the buffers; this block does not check it.
- FILL:
  - wr_done → READY.
  - wr_en is honoured.
- READY:
  - wr_en is blocked and overrun_cnt += 1 per strobe.
  - A wr_done pulse is ignored and overrun_cnt += 1.
- rd_swap in READY:
  - Next cycle: bank_sel toggles, state → FILL.
  - fill_req pulses that same next cycle.
- rd_swap in FILL (underrun):
  - No toggle; the reader re-reads the old bank.
  - underrun_cnt += 1.
  - The writer continues undisturbed.
- Simultaneous wr_done and rd_swap in FILL:
  - wr_done is evaluated first, so the swap is granted.
  - Next cycle: bank_sel toggles, state=FILL, fill_req pulses, no underrun is counted.
- Simultaneous wr_en and rd_swap in READY:
  - The write is blocked and counted as overrun.
  - The swap is granted.
- Read data alignment:
  - sel_d <= bank_sel each cycle.
  - rd_data is registered: rd_data <= sel_d ? m1_do : m0_do.
  - Total latency from rd_en to valid rd_data is 2 clk.
  - A read issued in the cycle before a toggle returns data from the old bank.
- Counters saturate at 2^CNT_W-1 and clear only on reset.
- Reset asserted mid-group: all state returns to its reset values; the partially written group is discarded; the new fill_req pulse follows reset release.

Decomposition:
- Shared package grp_pkg:
  - state enum {FILL, READY}
  - DATA_W / ADDR_W defaults
- Sub-module sat_counter (CNT_W parameter, inc/clear inputs), instantiated twice.
- The FSM, enable gating and read mux stay in the top module.

Test Plan:
- Reset release → exactly one fill_req pulse, 1 clk after release.
- Reset release → bank_sel=0, m1_we follows wr_en, m0_we=0.
- 1024 writes, then wr_done, then rd_swap → bank_sel=1 and fill_req pulse 1 clk after rd_swap.
- Same sequence → bank-1 data pattern 0x000..0x3FF appears on rd_data 2 clk after each rd_en.
- rd_swap with no wr_done → bank_sel stays 0, underrun_cnt=1, writes to bank 1 continue.
- After wr_done, 5 wr_en strobes and a second wr_done → m1_we stays 0, overrun_cnt=6.
- wr_done and rd_swap in the same cycle → swap granted, underrun_cnt stays 0.
- Read issued in the cycle before the toggle → returns bank-0 data.
- 300 refused swaps → underrun_cnt=255 (saturated).
- Reset mid-group → counters=0, bank_sel=0, fill_req pulses after release.

Source files
------------

// File: rtl/grp_pkg.sv
// Shared types and default widths for the group ping-pong buffer controller.
// Holds the writer-bank FSM state encoding and the default word/address widths.
package grp_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 10;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones and only clears on 'clear'.
// Ports: clk, clear (sync, dominant), inc (count one event), cnt (value).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grp_pingpong_ctrl.sv
// Ping-pong controller for two group buffers between frame filler and former.
// Ports: write side (wr_en/wr_addr/wr_done/fill_req), read side (rd_en/rd_swap/
// rd_data), bank enables (m*_we/m*_re), bank data (m*_do), bank_sel, counters.
module grp_pingpong_ctrl
    import grp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_done,
    output logic              fill_req,
    input  logic              rd_en,
    input  logic              rd_swap,
    output logic              m0_we,
    output logic              m1_we,
    output logic              m0_re,
    output logic              m1_re,
    input  logic [DATA_W-1:0] m0_do,
    input  logic [DATA_W-1:0] m1_do,
    output logic [DATA_W-1:0] rd_data,
    output logic              bank_sel,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt
);

    state_t state;
    logic   sel_d;
    logic   start_q;
    logic   wr_ok;
    logic   swap_ok;
    logic   underrun_inc;
    logic   overrun_inc;

    // The address goes to the buffers directly; nothing here looks at it.
    logic   addr_unused;
    assign addr_unused = ^wr_addr;

    assign wr_ok = wr_en && (state == FILL);

    // wr_done takes effect before rd_swap, so a same-cycle pair swaps.
    assign swap_ok      = rd_swap && ((state == READY) || wr_done);
    assign underrun_inc = rd_swap && (state == FILL) && !wr_done;
    assign overrun_inc  = (state == READY) && (wr_en || wr_done);

    assign m0_we = wr_ok &&  bank_sel;
    assign m1_we = wr_ok && !bank_sel;
    assign m0_re = rd_en && !bank_sel;
    assign m1_re = rd_en &&  bank_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            bank_sel <= 1'b0;
            fill_req <= 1'b0;
            start_q  <= 1'b1;
            sel_d    <= 1'b0;
            rd_data  <= '0;
        end else begin
            // sel_d tracks the bank that the buffers were read from last cycle.
            sel_d    <= bank_sel;
            rd_data  <= sel_d ? m1_do : m0_do;
            fill_req <= start_q || swap_ok;
            start_q  <= 1'b0;
            if (swap_ok) begin
                bank_sel <= ~bank_sel;
                state    <= FILL;
            end else if ((state == FILL) && wr_done) begin
                state <= READY;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_underrun (
        .clk   (clk),
        .clear (reset),
        .inc   (underrun_inc),
        .cnt   (underrun_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_overrun (
        .clk   (clk),
        .clear (reset),
        .inc   (overrun_inc),
        .cnt   (overrun_cnt)
    );

endmodule

// File: tb/tb_grp_pingpong_ctrl.sv
// Self-checking bench for grp_pingpong_ctrl with behavioural bank models.
// Read data is checked by a scoreboard queue popped by a separate monitor.
module tb_grp_pingpong_ctrl;

    localparam int DW = 12;
    localparam int AW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_done;
    logic          fill_req;
    logic          rd_en;
    logic          rd_swap;
    logic          m0_we, m1_we, m0_re, m1_re;
    logic [DW-1:0] m0_do, m1_do;
    logic [DW-1:0] rd_data;
    logic          bank_sel;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] overrun_cnt;

    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] mem0 [1024];
    logic [DW-1:0] mem1 [1024];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    always #5 clk = ~clk;

    grp_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_done      (wr_done),
        .fill_req     (fill_req),
        .rd_en        (rd_en),
        .rd_swap      (rd_swap),
        .m0_we        (m0_we),
        .m1_we        (m1_we),
        .m0_re        (m0_re),
        .m1_re        (m1_re),
        .m0_do        (m0_do),
        .m1_do        (m1_do),
        .rd_data      (rd_data),
        .bank_sel     (bank_sel),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    // Bank models: synchronous write, 1-cycle registered read.
    always @(posedge clk) begin
        if (m0_we) mem0[wr_addr] <= wr_data;
        if (m1_we) mem1[wr_addr] <= wr_data;
        if (m0_re) m0_do <= mem0[rd_addr];
        if (m1_re) m1_do <= mem1[rd_addr];
    end

    // rd_data is valid two edges after the cycle rd_en was driven.
    always @(posedge clk) begin
        v2 <= v1;
        v1 <= rd_en;
    end

    always @(negedge clk) begin
        if (v2) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: got %h with no expected entry", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 12'(i) ^ 12'h800;
            mem1[i] = 12'h0;
        end
        m0_do   = '0;
        m1_do   = '0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_done = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_swap = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, first cycle with reset low.
        chk("rst_fill_req", 32'(fill_req), 32'd0);
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        wr_en = 1'b1;
        #1;
        chk("rst_m1_we", 32'(m1_we), 32'd1);
        chk("rst_m0_we", 32'(m0_we), 32'd0);
        tick();
        chk("fill_req_pulse", 32'(fill_req), 32'd1);
        wr_en = 1'b0;
        tick();
        chk("fill_req_once", 32'(fill_req), 32'd0);

        // Fill bank 1; a refused swap happens in the middle.
        for (int i = 0; i < 1024; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(i);
            rd_swap = (i == 100);
            if (i == 500) begin
                #1;
                chk("underrun_m1_we", 32'(m1_we), 32'd1);
            end
            tick();
        end
        wr_en   = 1'b0;
        rd_swap = 1'b0;
        chk("underrun_bank_sel", 32'(bank_sel), 32'd0);
        chk("underrun_cnt_1", 32'(underrun_cnt), 32'd1);

        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;

        // Locked bank: strobes and a second wr_done count as overrun.
        for (int j = 0; j < 5; j++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(j);
            wr_data = 12'hFFF;
            #1;
            chk("locked_m1_we", 32'(m1_we), 32'd0);
            tick();
        end
        wr_en   = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        tick();
        chk("overrun_cnt_6", 32'(overrun_cnt), 32'd6);

        // Read issued together with the swap still sees bank 0.
        rd_en   = 1'b1;
        rd_addr = 10'd5;
        rd_swap = 1'b1;
        exp_q.push_back(12'h805);
        tick();
        rd_swap = 1'b0;
        chk("swap_bank_sel", 32'(bank_sel), 32'd1);
        chk("swap_fill_req", 32'(fill_req), 32'd1);

        // Drain bank 1: pattern 0x000..0x3FF.
        for (int i = 0; i < 1024; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            exp_q.push_back(DW'(i));
            tick();
        end
        rd_en = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // wr_done and rd_swap together: swap granted, no underrun.
        wr_done = 1'b1;
        rd_swap = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_swap = 1'b0;
        chk("simul_bank_sel", 32'(bank_sel), 32'd0);
        chk("simul_fill_req", 32'(fill_req), 32'd1);
        chk("simul_underrun", 32'(underrun_cnt), 32'd1);
        tick();
        chk("simul_fill_req_end", 32'(fill_req), 32'd0);

        // Saturation of the underrun counter.
        rd_swap = 1'b1;
        repeat (300) tick();
        rd_swap = 1'b0;
        tick();
        chk("underrun_sat", 32'(underrun_cnt), 32'd255);
        chk("sat_bank_sel", 32'(bank_sel), 32'd0);

        // Reset in the middle of a group.
        wr_en = 1'b1;
        repeat (4) tick();
        wr_en = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("mid_underrun", 32'(underrun_cnt), 32'd0);
        chk("mid_overrun", 32'(overrun_cnt), 32'd0);
        chk("mid_bank_sel", 32'(bank_sel), 32'd0);
        chk("mid_fill_req_0", 32'(fill_req), 32'd0);
        tick();
        chk("mid_fill_req_1", 32'(fill_req), 32'd1);
        wr_en = 1'b1;
        #1;
        chk("mid_m1_we", 32'(m1_we), 32'd1);
        tick();
        wr_en = 1'b0;
        chk("mid_fill_req_end", 32'(fill_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
